pal_sop_array: RTL and testbench
================================

Name: pal_sop_array

Overview:
Programmable sum-of-products array. It is the configurable successor to our fixed AND-OR gate chips. Each of N_OUT outputs is the OR of N_TERMS product terms. Each term is an AND over any selection of true or complemented inputs. Configuration is loaded serially, and evaluation is registered with a valid handshake.

Parameters:
- N_IN, 6, number of input signals.
- N_TERMS, 2, product terms per output.
- N_OUT, 2, number of outputs.
- CFG_BITS (derived, not overridable), N_OUT*N_TERMS*2*N_IN, total configuration bits (48 at defaults).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  pulse that begins a new configuration load.
- cfg_en  in  1  qualifies cfg_bit on this cycle.
- cfg_bit  in  1  serial configuration data.
- cfg_done  out  1  high while in RUN (configuration complete).
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  N_IN  input vector.
- out_valid  out  1  out_data is valid.
- out_data  out  N_OUT  registered SOP results.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - Configuration register cleared to all zeros; beat counter = 0.
  - cfg_done = 0, out_valid = 0, out_data = 0.
- FSM states are IDLE (unconfigured), LOAD and RUN.
  - Any state, cfg_start=1 -> LOAD. Counter = 0, config register cleared, out_valid = 0, out_data = 0.
  - LOAD, cfg_en=1: shift in, with config <= {config[CFG_BITS-2:0], cfg_bit}, and counter++.
  - LOAD, on the beat where counter == CFG_BITS-1 and cfg_en=1: go to RUN. cfg_done rises the following cycle.
  - LOAD, cfg_en=0: no shift and no count. Gaps of any length are legal.
  - cfg_start and cfg_en in the same cycle: cfg_start wins and the bit is discarded.
  - cfg_en in IDLE or RUN is ignored.
- Bit mapping after the load completes. The first bit shifted ends at index CFG_BITS-1.
  - Bit o*N_TERMS*2*N_IN + t*2*N_IN + l controls output o, term t, literal l.
  - If l < N_IN, the bit includes in_data[l].
  - If l >= N_IN, the bit includes ~in_data[l-N_IN].
- Term evaluation:
  - term = AND of all selected literals.
  - A term with no literals selected evaluates to 0 (disabled), not 1.
  - A term selecting both x and ~x evaluates to 0 naturally.
  - out_data[o] = OR of its N_TERMS terms.
- Data path, RUN only:
  - in_valid=1 at cycle n gives out_valid=1 with the corresponding out_data at cycle n+1. Latency is exactly 1 cycle; back-to-back inputs are accepted every cycle.
  - in_valid=0 gives out_valid=0 the next cycle; out_data holds its last value.
  - There is no backpressure.
- In IDLE and LOAD, in_valid is ignored and out_valid stays 0.
- Reset mid-LOAD or mid-RUN returns to the reset state on the next edge; any partial configuration is lost.
- Reconfiguring from RUN (cfg_start) drops cfg_done the next cycle.

Decomposition:
- Shared package pal_pkg holds:
  - the state enum (IDLE, LOAD, RUN);
  - a function cfg_idx(o, t, l) returning the bit index;
  - the CFG_BITS derivation as a function of the three parameters.
- Sub-module pal_term: combinational, parameter N_IN. Inputs are in_data and a 2*N_IN literal mask; output is the term value, including the empty-mask-gives-0 rule. It is instantiated N_OUT*N_TERMS times.
- The top level holds the FSM, beat counter, shift register, OR reduction and output registers.

Test Plan:
- Reset behaviour: assert reset for 2 cycles, then drive in_valid=1 with in_data=6'h3F. Required: cfg_done=0, out_valid=0 and out_data=0 on every cycle.
- Full load and evaluate. Configure out0 = in0&in1&in2 | in3&in4&in5 and out1 = in0&~in1 | disabled term. Send 48 beats.
  - Required: cfg_done=1 one cycle after the last beat.
  - in_data=6'b000111 -> out_data=2'b01 one cycle later.
  - in_data=6'b000001 -> out_data=2'b10.
  - in_data=6'b111000 -> out_data=2'b01.
  - in_data=0 -> out_data=2'b00.
- All-zero configuration (48 zero beats): any in_data, including 6'h00 and 6'h3F -> out_data=2'b00 with out_valid=1.
- Gapped load: insert random cfg_en=0 cycles between the 48 beats. Required: results identical to the gap-free load.
- Restart: cfg_start after 20 beats, with cfg_en=1 in the same cycle. Required: that bit is discarded and cfg_done stays 0 until 48 further beats.
- Streaming: 5 consecutive in_valid cycles, then a gap. Required: out_valid is high for exactly 5 cycles, each delayed by 1. During the gap out_data holds. Reset mid-stream -> out_valid=0 and out_data=0 the next cycle.

Source files
------------

// File: rtl/pal_pkg.sv
// pal_sop_array shared types: FSM states and configuration bit layout.
package pal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic int cfg_bits(
    input int n_in,
    input int n_terms,
    input int n_out
  );
    return n_out * n_terms * 2 * n_in;
  endfunction

  function automatic int cfg_idx(
    input int o,
    input int t,
    input int l,
    input int n_in,
    input int n_terms
  );
    return o * n_terms * 2 * n_in + t * 2 * n_in + l;
  endfunction

endpackage

// File: rtl/pal_term.sv
// One product term: AND of the selected true/complemented literals.
module pal_term #(
  parameter int N_IN = 6
) (
  input  logic [N_IN-1:0]   in_data_i,
  input  logic [2*N_IN-1:0] mask_i,
  output logic              term_o
);

  logic [2*N_IN-1:0] lits_w;

  assign lits_w = {~in_data_i, in_data_i};

  // An empty mask would AND to 1; force it to a disabled (0) term.
  assign term_o = (|mask_i) & (&(lits_w | ~mask_i));

endmodule

// File: rtl/pal_sop_array.sv
// Programmable sum-of-products array with serial config load
// and a one-cycle registered evaluation path.
module pal_sop_array
  import pal_pkg::*;
#(
  parameter int N_IN    = 6,
  parameter int N_TERMS = 2,
  parameter int N_OUT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_en,
  input  logic             cfg_bit,
  output logic             cfg_done,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  output logic [N_OUT-1:0] out_data
);

  localparam int CFG_BITS = cfg_bits(N_IN, N_TERMS, N_OUT);
  localparam int CW = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(CFG_BITS - 1);

  state_e              state_q, state_d;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                vld_q, vld_d;
  logic [N_OUT-1:0]    dat_q, dat_d;

  logic [N_OUT-1:0][N_TERMS-1:0] term_w;
  logic [N_OUT-1:0]              sop_w;

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    for (genvar t = 0; t < N_TERMS; t++) begin : g_term
      localparam int B = cfg_idx(o, t, 0, N_IN, N_TERMS);
      pal_term #(
        .N_IN(N_IN)
      ) u_term (
        .in_data_i(in_data),
        .mask_i   (cfg_q[B +: 2*N_IN]),
        .term_o   (term_w[o][t])
      );
    end
    assign sop_w[o] = |term_w[o];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    dat_d   = dat_q;
    // A restart beats any beat offered in the same cycle.
    if (cfg_start) begin
      state_d = LOAD;
      cfg_d   = '0;
      cnt_d   = '0;
      dat_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (cfg_en) begin
            cfg_d = {cfg_q[CFG_BITS-2:0], cfg_bit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_d = RUN;
              cnt_d   = '0;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            vld_d = 1'b1;
            dat_d = sop_w;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_done  = (state_q == RUN);
  assign out_valid = vld_q;
  assign out_data  = dat_q;

endmodule

// File: tb/tb_pal_sop_array.sv
// Bench for pal_sop_array: vector tables, corner sequences and
// randomized loads/streams against a queue-based reference model.
module tb_pal_sop_array;

  localparam int NI = 6;
  localparam int NT = 2;
  localparam int NO = 2;
  localparam int CB = NO * NT * 2 * NI;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_en = 1'b0;
  logic          cfg_bit = 1'b0;
  logic          cfg_done;
  logic          in_valid = 1'b0;
  logic [NI-1:0] in_data = '0;
  logic          out_valid;
  logic [NO-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pal_sop_array #(
    .N_IN(NI), .N_TERMS(NT), .N_OUT(NO)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_en(cfg_en),
    .cfg_bit(cfg_bit), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  // Reference model: bits kept in arrival order.
  int            m_state = 0;
  bit            m_q[$];
  bit            m_vld = 1'b0;
  logic [NO-1:0] m_dat = '0;

  function automatic logic [NO-1:0] ref_eval(
    input logic [NI-1:0] x
  );
    logic [NO-1:0] r;
    r = '0;
    for (int o = 0; o < NO; o++) begin
      for (int t = 0; t < NT; t++) begin
        int nsel;
        bit all;
        nsel = 0;
        all = 1'b1;
        for (int l = 0; l < 2 * NI; l++) begin
          int idx;
          bit lit;
          idx = o * NT * 2 * NI + t * 2 * NI + l;
          lit = (l < NI) ? x[l] : !x[l-NI];
          if (m_q[CB-1-idx]) begin
            nsel++;
            if (!lit) all = 1'b0;
          end
        end
        if (nsel > 0 && all) r[o] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model(
    input logic rs, st, en, b, iv,
    input logic [NI-1:0] d
  );
    if (rs || st) begin
      m_state = rs ? 0 : 1;
      m_q.delete();
      m_vld = 1'b0;
      m_dat = '0;
    end else begin
      m_vld = 1'b0;
      if (m_state == 1 && en) begin
        m_q.push_back(b);
        if (m_q.size() == CB) m_state = 2;
      end else if (m_state == 2 && iv) begin
        m_vld = 1'b1;
        m_dat = ref_eval(d);
      end
    end
  endtask

  task automatic chk(
    input string name,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step(
    input logic rs, st, en, b, iv,
    input logic [NI-1:0] d
  );
    reset = rs;
    cfg_start = st;
    cfg_en = en;
    cfg_bit = b;
    in_valid = iv;
    in_data = d;
    @(posedge clk);
    model(rs, st, en, b, iv, d);
    #1;
    chk("m_cfg_done", 8'(cfg_done), 8'(m_state == 2));
    chk("m_out_valid", 8'(out_valid), 8'(m_vld));
    chk("m_out_data", 8'(out_data), 8'(m_dat));
  endtask

  task automatic idle_cyc();
    step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
         1'b0, 6'($urandom));
  endtask

  // Beats MSB first so cfg[i] lands at register index i.
  task automatic load(input logic [CB-1:0] cfg, input bit gaps);
    for (int k = 0; k < CB; k++) begin
      while (gaps && $urandom_range(0, 2) == 0)
        step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 6'($urandom));
      step(1'b0, 1'b0, 1'b1, cfg[CB-1-k],
           1'($urandom_range(0, 1)), 6'($urandom));
    end
  endtask

  typedef struct {
    logic [NI-1:0] din;
    logic [NO-1:0] exp;
  } vec_t;

  vec_t tbl[4];

  task automatic run_table(input string tag);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tbl[i].din);
      chk({tag, "_vld"}, 8'(out_valid), 8'd1);
      chk({tag, "_dat"}, 8'(out_data), 8'(tbl[i].exp));
    end
  endtask

  logic [CB-1:0] cfg_a;
  logic [CB-1:0] cfg_r;
  logic [NO-1:0] last;
  int            vcnt;

  initial begin
    tbl[0] = '{6'b000111, 2'b01};
    tbl[1] = '{6'b000001, 2'b10};
    tbl[2] = '{6'b111000, 2'b01};
    tbl[3] = '{6'b000000, 2'b00};

    // out0 = i0&i1&i2 | i3&i4&i5 ; out1 = i0&~i1 | (disabled)
    cfg_a = '0;
    cfg_a[0] = 1'b1; cfg_a[1] = 1'b1; cfg_a[2] = 1'b1;
    cfg_a[15] = 1'b1; cfg_a[16] = 1'b1; cfg_a[17] = 1'b1;
    cfg_a[24] = 1'b1; cfg_a[31] = 1'b1;

    // Reset, then inputs while unconfigured
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h3F);
      chk("rst_done", 8'(cfg_done), 8'd0);
      chk("rst_vld", 8'(out_valid), 8'd0);
      chk("rst_dat", 8'(out_data), 8'd0);
    end

    // Gap-free load of the reference configuration
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    load(cfg_a, 1'b0);
    chk("load_done", 8'(cfg_done), 8'd1);
    run_table("full");

    // All-zero configuration disables every term
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    load('0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00);
    chk("zero_vld0", 8'(out_valid), 8'd1);
    chk("zero_dat0", 8'(out_data), 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);
    chk("zero_vld1", 8'(out_valid), 8'd1);
    chk("zero_dat1", 8'(out_data), 8'd0);

    // Gapped load must behave exactly like the gap-free one
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    load(cfg_a, 1'b1);
    chk("gap_done", 8'(cfg_done), 8'd1);
    run_table("gap");

    // Restart from RUN, then again after 20 beats with cfg_en set
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rcfg_drop", 8'(cfg_done), 8'd0);
    for (int k = 0; k < 20; k++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < CB; k++) begin
      chk("rst_pend", 8'(cfg_done), 8'd0);
      step(1'b0, 1'b0, 1'b1, cfg_a[CB-1-k], 1'b0, '0);
    end
    chk("rst_done2", 8'(cfg_done), 8'd1);
    run_table("restart");

    // Streaming: 5 back-to-back inputs, then a gap
    vcnt = 0;
    last = '0;
    for (int i = 0; i < 5; i++) begin
      in_data = 6'($urandom);
      last = ref_eval(in_data);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, in_data);
      chk("strm_dat", 8'(out_data), 8'(last));
      if (out_valid) vcnt++;
    end
    for (int i = 0; i < 4; i++) begin
      idle_cyc();
      if (out_valid) vcnt++;
      chk("strm_hold", 8'(out_data), 8'(last));
    end
    chk("strm_cnt", 8'(vcnt), 8'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000111);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000111);
    chk("mid_rst_vld", 8'(out_valid), 8'd0);
    chk("mid_rst_dat", 8'(out_data), 8'd0);
    chk("mid_rst_done", 8'(cfg_done), 8'd0);

    // Randomized rounds against the reference model
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'($urandom));
      for (int i = 0; i < CB; i++)
        cfg_r[i] = ($urandom_range(0, 3) == 0);
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1,
           1'b1, 6'($urandom));
      load(cfg_r, 1'b1);
      for (int i = 0; i < 40; i++) begin
        logic st;
        st = ($urandom_range(0, 59) == 0);
        step(1'b0, st, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), 6'($urandom));
        if (st) load(cfg_r, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
